// File: rtl/mac_pkg.sv
// Shared types and width helpers for the multi-lane MAC accumulate stage.
// saturate() works on values extended to SAT_MAX_W bits, so the accumulator
// width (2*DATA_W+$clog2(K)) must not exceed SAT_MAX_W.
package mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } mac_state_t;

  localparam int SAT_MAX_W = 128;

  function automatic int prod_width(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k);
  endfunction

  // Clamp an already sign/zero-extended value to the range of an out_w-bit
  // signed or unsigned number; the caller keeps the low out_w bits.
  function automatic logic [SAT_MAX_W-1:0] saturate(input logic [SAT_MAX_W-1:0] val,
                                                    input int out_w,
                                                    input bit is_signed);
    logic signed [SAT_MAX_W-1:0] sval;
    logic signed [SAT_MAX_W-1:0] smax;
    logic signed [SAT_MAX_W-1:0] smin;
    logic [SAT_MAX_W-1:0]        umax;
    logic [SAT_MAX_W-1:0]        one;
    logic [SAT_MAX_W-1:0]        res;
    one  = SAT_MAX_W'(1);
    sval = $signed(val);
    smax = $signed((one << (out_w - 1)) - one);
    smin = ~smax;
    umax = (one << out_w) - one;
    res  = val;
    if (is_signed) begin
      if (sval > smax)      res = smax;
      else if (sval < smin) res = smin;
    end else begin
      if (val > umax)       res = umax;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_lane_adder_tree.sv
// Combinational balanced reduction of LANES products into one beat sum.
// Nodes are laid out as a heap: leaves at [LANES-1 .. 2*LANES-2], root at 0.
// The sum is wide enough that it never overflows.
module mac_lane_adder_tree #(
  parameter int LANES  = 1,
  parameter int PROD_W = 64,
  parameter int SIGNED = 0,
  localparam int SUM_W = PROD_W + $clog2(LANES)
) (
  input  logic [LANES*PROD_W-1:0] prod,
  output logic [SUM_W-1:0]        sum
);

  logic [SUM_W-1:0] node [2*LANES-1];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_leaf
      logic [PROD_W-1:0] lane;
      assign lane = prod[gi*PROD_W +: PROD_W];
      if (SIGNED != 0) begin : g_sx
        logic signed [PROD_W-1:0] lane_s;
        assign lane_s = $signed(lane);
        assign node[LANES-1+gi] = SUM_W'(lane_s);
      end else begin : g_zx
        assign node[LANES-1+gi] = SUM_W'(lane);
      end
    end
    for (gi = 0; gi < LANES - 1; gi++) begin : g_node
      assign node[gi] = node[2*gi+1] + node[2*gi+2];
    end
  endgenerate

  assign sum = node[0];

endmodule

// File: rtl/mac_accum_lanes.sv
// MAC accumulate stage: reduces LANES products per beat into a per-element
// accumulator over K, then emits the finished C element with its row/col on
// a valid/ready port. mac_done flags acceptance of the element tagged in_last.
// Build option MAC_ACCUM_SAT_EN: clamp instead of wrap when OUT_W < ACC_W.
module mac_accum_lanes
  import mac_pkg::*;
#(
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int LANES  = 1,
  parameter int SIGNED = 0,
  parameter int OUT_W  = 2 * DATA_W + $clog2(K),
  localparam int PROD_W = prod_width(DATA_W),
  localparam int ACC_W  = acc_width(DATA_W, K),
  localparam int SUM_W  = PROD_W + $clog2(LANES),
  localparam int KIDX_W = $clog2(K),
  localparam int ROW_W  = $clog2(M),
  localparam int COL_W  = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*PROD_W-1:0] in_prod,
  input  logic [KIDX_W-1:0]       in_k_idx,
  input  logic [ROW_W-1:0]        in_row,
  input  logic [COL_W-1:0]        in_col,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [ROW_W-1:0]        out_row,
  output logic [COL_W-1:0]        out_col,
  output logic                    mac_done,
  output logic                    err
);

  mac_state_t state_reg, state_next;

  logic [ACC_W-1:0] acc_reg, acc_next;
  logic             err_reg, err_next;
  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic [ROW_W-1:0] out_row_reg;
  logic [COL_W-1:0] out_col_reg;
  logic             out_last_reg;

  logic [SUM_W-1:0] tree_sum;
  logic [ACC_W-1:0] beat_sum;
  logic [ACC_W-1:0] acc_plus;
  logic [ACC_W-1:0] result;
  logic             load;

  logic beat_fire;
  logic out_fire;
  logic k_first;
  logic k_last;
  logic k_aligned;

  mac_lane_adder_tree #(
    .LANES  (LANES),
    .PROD_W (PROD_W),
    .SIGNED (SIGNED)
  ) u_tree (
    .prod (in_prod),
    .sum  (tree_sum)
  );

  // Widen the beat sum and the result according to the arithmetic mode.
  logic [SAT_MAX_W-1:0] result_ext;
  logic [SAT_MAX_W-1:0] result_red;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [SUM_W-1:0] tree_sum_s;
      logic signed [ACC_W-1:0] result_s;
      assign tree_sum_s = $signed(tree_sum);
      assign beat_sum   = ACC_W'(tree_sum_s);
      assign result_s   = $signed(result);
      assign result_ext = SAT_MAX_W'(result_s);
    end else begin : g_unsigned
      assign beat_sum   = ACC_W'(tree_sum);
      assign result_ext = SAT_MAX_W'(result);
    end
  endgenerate

`ifdef MAC_ACCUM_SAT_EN
  assign result_red = (OUT_W < ACC_W) ? saturate(result_ext, OUT_W, SIGNED != 0) : result_ext;
`else
  assign result_red = result_ext;
`endif

  // A held output stalls every beat.
  assign in_ready  = ~out_valid_reg | out_ready;
  assign beat_fire = in_valid & in_ready;
  assign out_fire  = out_valid_reg & out_ready;
  assign k_first   = (in_k_idx == '0);
  assign k_last    = (in_k_idx == KIDX_W'(K - LANES));
  assign k_aligned = ((int'(in_k_idx) % LANES) == 0);
  assign acc_plus  = acc_reg + beat_sum;

  // Next-state, accumulator update, error detection and output-load decision.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    err_next   = err_reg;
    load       = 1'b0;
    result     = beat_sum;
    if (start) begin
      // start re-arms and drops any beat arriving with it
      state_next = S_IDLE;
      err_next   = 1'b0;
    end else begin
      if (beat_fire) begin
        if (state_reg == S_DONE || !k_aligned) begin
          err_next = 1'b1;
        end else if (state_reg == S_IDLE) begin
          if (!k_first) begin
            err_next = 1'b1;
          end else if (k_last) begin
            load   = 1'b1;
            result = beat_sum;
          end else begin
            acc_next   = beat_sum;
            state_next = S_ACCUM;
          end
        end else begin
          if (k_first) begin
            err_next = 1'b1;
            acc_next = beat_sum;
          end else if (k_last) begin
            load       = 1'b1;
            result     = acc_plus;
            state_next = S_IDLE;
          end else begin
            acc_next = acc_plus;
          end
        end
      end
      if (out_fire && out_last_reg) begin
        state_next = S_DONE;
      end
    end
  end

  // FSM, accumulator and sticky error registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      err_reg   <= err_next;
    end
  end

  // Output register: loads a finished element, holds it until accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_row_reg   <= '0;
      out_col_reg   <= '0;
      out_last_reg  <= 1'b0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= OUT_W'(result_red);
      out_row_reg   <= in_row;
      out_col_reg   <= in_col;
      out_last_reg  <= in_last;
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_row   = out_row_reg;
  assign out_col   = out_col_reg;
  assign mac_done  = (state_reg == S_DONE);
  assign err       = err_reg;

endmodule

// File: tb/tb_mac_accum_lanes.sv
// Directed bench for mac_accum_lanes. Five instances cover: 1 lane unsigned,
// 2 lanes unsigned, 1 lane signed, and OUT_W=8 unsigned/signed reduction.
// Expected reduction values follow MAC_ACCUM_SAT_EN when it is defined.
module tb_mac_accum_lanes;

  logic         clk = 1'b0;
  logic         resetn;
  logic [4:0]   st;
  logic [4:0]   v;
  logic [127:0] prod;
  logic [1:0]   kidx;
  logic [1:0]   row;
  logic [1:0]   col;
  logic         last;
  logic         rdy;

  logic [4:0]      ir, ov, dn, er;
  logic [4:0][1:0] orow, ocol;
  logic [65:0]     od0, od1, od2;
  logic [7:0]      od3, od4;

  int errors = 0;
  int checks = 0;
  int wr [5] = '{0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  mac_accum_lanes u_a (
    .clk(clk), .resetn(resetn), .start(st[0]), .in_valid(v[0]), .in_ready(ir[0]),
    .in_prod(prod[63:0]), .in_k_idx(kidx), .in_row(row), .in_col(col), .in_last(last),
    .out_valid(ov[0]), .out_ready(rdy), .out_data(od0), .out_row(orow[0]), .out_col(ocol[0]),
    .mac_done(dn[0]), .err(er[0]));

  mac_accum_lanes #(.LANES(2)) u_b (
    .clk(clk), .resetn(resetn), .start(st[1]), .in_valid(v[1]), .in_ready(ir[1]),
    .in_prod(prod), .in_k_idx(kidx), .in_row(row), .in_col(col), .in_last(last),
    .out_valid(ov[1]), .out_ready(rdy), .out_data(od1), .out_row(orow[1]), .out_col(ocol[1]),
    .mac_done(dn[1]), .err(er[1]));

  mac_accum_lanes #(.SIGNED(1)) u_c (
    .clk(clk), .resetn(resetn), .start(st[2]), .in_valid(v[2]), .in_ready(ir[2]),
    .in_prod(prod[63:0]), .in_k_idx(kidx), .in_row(row), .in_col(col), .in_last(last),
    .out_valid(ov[2]), .out_ready(rdy), .out_data(od2), .out_row(orow[2]), .out_col(ocol[2]),
    .mac_done(dn[2]), .err(er[2]));

  mac_accum_lanes #(.OUT_W(8)) u_d (
    .clk(clk), .resetn(resetn), .start(st[3]), .in_valid(v[3]), .in_ready(ir[3]),
    .in_prod(prod[63:0]), .in_k_idx(kidx), .in_row(row), .in_col(col), .in_last(last),
    .out_valid(ov[3]), .out_ready(rdy), .out_data(od3), .out_row(orow[3]), .out_col(ocol[3]),
    .mac_done(dn[3]), .err(er[3]));

  mac_accum_lanes #(.SIGNED(1), .OUT_W(8)) u_e (
    .clk(clk), .resetn(resetn), .start(st[4]), .in_valid(v[4]), .in_ready(ir[4]),
    .in_prod(prod[63:0]), .in_k_idx(kidx), .in_row(row), .in_col(col), .in_last(last),
    .out_valid(ov[4]), .out_ready(rdy), .out_data(od4), .out_row(orow[4]), .out_col(ocol[4]),
    .mac_done(dn[4]), .err(er[4]));

  // Count accepted output writes per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (ov[i] && rdy) wr[i] <= wr[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] p1(input int a);
    logic [63:0] t;
    t = 64'(a);
    return {64'd0, t};
  endfunction

  function automatic logic [127:0] p2(input int a, input int b);
    logic [63:0] ta;
    logic [63:0] tb;
    ta = 64'(a);
    tb = 64'(b);
    return {tb, ta};
  endfunction

  // Present one beat to instance inst; returns at the following negedge.
  task automatic beat(input int inst, input logic [127:0] p, input int k,
                      input int r, input int c, input bit l);
    prod    = p;
    kidx    = k[1:0];
    row     = r[1:0];
    col     = c[1:0];
    last    = l;
    v[inst] = 1'b1;
    @(negedge clk);
    v    = '0;
    last = 1'b0;
  endtask

  task automatic pulse_start(input int inst);
    st[inst] = 1'b1;
    @(negedge clk);
    st = '0;
  endtask

  initial begin
    int exp_sum;
    int base;
    resetn = 1'b0;
    st = '0; v = '0; prod = '0; kidx = '0; row = '0; col = '0; last = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state of every instance
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_in_ready%0d", i), ir[i], 1);
      check($sformatf("rst_out_valid%0d", i), ov[i], 0);
      check($sformatf("rst_done%0d", i), dn[i], 0);
      check($sformatf("rst_err%0d", i), er[i], 0);
    end
    check("rst_data0", od0, 0);
    check("rst_data1", od1, 0);
    check("rst_data2", od2, 0);
    check("rst_data3", od3, 0);
    check("rst_data4", od4, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single lane, one element, then backpressure hold
    beat(0, p1(28), 0, 0, 0, 0);
    beat(0, p1(18), 1, 0, 0, 0);
    beat(0, p1(16), 2, 0, 0, 0);
    beat(0, p1(25), 3, 0, 0, 0);
    check("l1_valid", ov[0], 1);
    check("l1_data", od0, 87);
    check("l1_row", orow[0], 0);
    check("l1_col", ocol[0], 0);
    check("bp_in_ready", ir[0], 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), ov[0], 1);
      check($sformatf("bp_hold_data%0d", i), od0, 87);
      check($sformatf("bp_hold_rowcol%0d", i), {orow[0], ocol[0]}, 0);
    end
    rdy = 1'b1;
    #1;
    check("bp_release_ready", ir[0], 1);
    @(negedge clk);
    check("bp_drained", ov[0], 0);
    check("bp_writes", wr[0], 1);

    // Full 4x4x4 matrix, in_last on element (3,3)
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        base = 16 * r + 4 * c;
        exp_sum = 0;
        for (int k = 0; k < 4; k++) begin
          beat(0, p1(base + k + 1), k, r, c, (r == 3) && (c == 3));
          exp_sum += base + k + 1;
        end
        check($sformatf("mat_valid_%0d_%0d", r, c), ov[0], 1);
        check($sformatf("mat_data_%0d_%0d", r, c), od0, 128'(exp_sum));
        check($sformatf("mat_row_%0d_%0d", r, c), orow[0], 128'(r));
        check($sformatf("mat_col_%0d_%0d", r, c), ocol[0], 128'(c));
        check($sformatf("mat_done_early_%0d_%0d", r, c), dn[0], 0);
      end
    end
    @(negedge clk);
    check("mat_done", dn[0], 1);
    check("mat_drained", ov[0], 0);
    check("mat_writes", wr[0], 17);
    check("mat_err_clean", er[0], 0);

    // Stray beat after completion
    beat(0, p1(5), 0, 0, 0, 0);
    check("stray_err", er[0], 1);
    check("stray_no_out", ov[0], 0);
    check("stray_done_held", dn[0], 1);
    pulse_start(0);
    check("start_clr_done", dn[0], 0);
    check("start_clr_err", er[0], 0);

    // Beat with k_idx=2 while idle is dropped
    beat(0, p1(7), 2, 1, 1, 0);
    check("idle_k2_err", er[0], 1);
    @(negedge clk);
    check("idle_k2_no_out", ov[0], 0);
    check("idle_k2_writes", wr[0], 17);
    pulse_start(0);

    // Two lanes, two elements back to back
    beat(1, p2(28, 18), 0, 0, 1, 0);
    beat(1, p2(16, 25), 2, 0, 1, 0);
    check("l2_valid_a", ov[1], 1);
    check("l2_data_a", od1, 87);
    check("l2_row_a", orow[1], 0);
    check("l2_col_a", ocol[1], 1);
    check("l2_no_bubble", ir[1], 1);
    beat(1, p2(24, 21), 0, 1, 2, 0);
    beat(1, p2(10, 40), 2, 1, 2, 0);
    check("l2_valid_b", ov[1], 1);
    check("l2_data_b", od1, 95);
    check("l2_row_b", orow[1], 1);
    check("l2_col_b", ocol[1], 2);
    @(negedge clk);
    check("l2_writes", wr[1], 2);
    check("l2_drained", ov[1], 0);
    check("l2_err_clean", er[1], 0);
    beat(1, p2(1, 1), 1, 0, 0, 0);
    check("l2_misaligned_err", er[1], 1);

    // Signed accumulation
    beat(2, p1(-3), 0, 2, 3, 0);
    beat(2, p1(5), 1, 2, 3, 0);
    beat(2, p1(-7), 2, 2, 3, 0);
    beat(2, p1(2), 3, 2, 3, 0);
    check("sgn_valid", ov[2], 1);
    check("sgn_data", od2, 128'(66'h3_FFFF_FFFF_FFFF_FFFD));
    check("sgn_row", orow[2], 2);
    check("sgn_col", ocol[2], 3);

    // Narrow output, unsigned sum 300
    beat(3, p1(100), 0, 0, 0, 0);
    beat(3, p1(100), 1, 0, 0, 0);
    beat(3, p1(50), 2, 0, 0, 0);
    beat(3, p1(50), 3, 0, 0, 0);
    check("narrow_u_valid", ov[3], 1);
`ifdef MAC_ACCUM_SAT_EN
    check("narrow_u_data", od3, 255);
`else
    check("narrow_u_data", od3, 44);
`endif

    // Narrow output, signed sum -200
    for (int k = 0; k < 4; k++) beat(4, p1(-50), k, 1, 0, 0);
    check("narrow_s_valid", ov[4], 1);
`ifdef MAC_ACCUM_SAT_EN
    check("narrow_s_data", od4, 8'h80);
`else
    check("narrow_s_data", od4, 8'h38);
`endif
    check("narrow_s_row", orow[4], 1);
    @(negedge clk);
    check("err_clean_c", er[2], 0);
    check("err_clean_d", er[3], 0);
    check("err_clean_e", er[4], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
